// File: rtl/tpu_apb_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tpu_apb_seq: APB weight loader, input feeder and checksum reader for a TPU   |
// | array. Optional RUN watchdog: TPU_APB_SEQ_TIMEOUT_EN.                        |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module tpu_apb_seq #(
   parameter int N       = 2,
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int ROWS    = 4,
   parameter int NRD     = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_go,
   input  logic [DW-1:0]   i_wseed,
   input  logic [DW-1:0]   i_wstep,
   input  logic [DW-1:0]   i_iseed,
   input  logic [DW-1:0]   i_expect,
   output logic [AW-1:0]   o_paddr,
   output logic            o_psel,
   output logic            o_penable,
   output logic            o_pwrite,
   output logic [DW-1:0]   o_pwdata,
   input  logic [DW-1:0]   i_prdata,
   output logic [N*DW-1:0] o_in_data,
   output logic [N-1:0]    o_in_en,
   output logic            o_start,
   input  logic            i_done,
   output logic            o_busy,
   output logic            o_end,
   output logic            o_pass,
   output logic            o_fail,
   output logic            o_timeout,
   output logic [DW-1:0]   o_sum
);

   localparam int KW  = $clog2(N*N + 1);
   localparam int RW  = $clog2(ROWS + 1);
   localparam int DRW = $clog2(NRD + 1);
   localparam logic [KW-1:0]  K_LAST = KW'(N*N - 1);
   localparam logic [RW-1:0]  R_LAST = RW'(ROWS - 1);
   localparam logic [DRW-1:0] D_LAST = DRW'(NRD - 1);

   typedef enum logic [2:0] {
      IDLE, WSETUP, WACCESS, FEED, RUN, RSETUP, RACCESS, FIN
   } state_t;

   state_t           state, state_nxt;
   logic             launch;
   logic [KW-1:0]    widx;
   logic [RW-1:0]    row;
   logic [DRW-1:0]   rd_cnt;
   logic [DW-1:0]    sum;
   logic             pass_q, fail_q;
   logic             aborted;
   logic             run_expired;
   logic             verdict;
   logic             go_accept;
   logic [DW-1:0]    wdata;

   // The accepted i_go spends one extra IDLE cycle (launch) before the first APB setup.
   assign go_accept = (state == IDLE) && !launch && i_go;
   assign wdata     = i_wseed + DW'(widx) * i_wstep;
   assign verdict   = (sum == i_expect) && !aborted;

`ifdef TPU_APB_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] run_cnt;

   assign run_expired = (run_cnt == T_LAST) && !i_done;
   assign o_timeout   = aborted;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         run_cnt <= '0;
         aborted <= 1'b0;
      end else if (go_accept) begin
         run_cnt <= '0;
         aborted <= 1'b0;
      end else if (state == RUN) begin
         run_cnt <= run_cnt + 1'b1;
         if (run_expired)
            aborted <= 1'b1;
      end
   end
`else
   // RUN waits for i_done indefinitely; the watchdog never fires.
   assign run_expired = 1'b0 && (TIMEOUT > 0);
   assign aborted     = 1'b0;
   assign o_timeout   = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= IDLE;
         launch <= 1'b0;
         widx   <= '0;
         row    <= '0;
         rd_cnt <= '0;
         sum    <= '0;
         pass_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (launch) begin
                  launch <= 1'b0;
               end else if (i_go) begin
                  launch <= 1'b1;
                  widx   <= '0;
                  row    <= '0;
                  rd_cnt <= '0;
                  sum    <= '0;
                  pass_q <= 1'b0;
                  fail_q <= 1'b0;
               end
            end
            WACCESS: widx <= widx + 1'b1;
            FEED:    row  <= row + 1'b1;
            RACCESS: begin
               sum    <= sum + i_prdata;
               rd_cnt <= rd_cnt + 1'b1;
            end
            FIN: begin
               pass_q <= verdict;
               fail_q <= !verdict;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      o_psel    = 1'b0;
      o_penable = 1'b0;
      o_pwrite  = 1'b0;
      o_paddr   = '0;
      o_pwdata  = '0;
      o_start   = 1'b0;
      o_end     = 1'b0;
      o_busy    = (state != IDLE);
      o_pass    = pass_q;
      o_fail    = fail_q;
      case (state)
         IDLE: begin
            if (launch)
               state_nxt = WSETUP;
         end
         WSETUP: begin
            o_psel    = 1'b1;
            o_pwrite  = 1'b1;
            o_paddr   = AW'(widx);
            o_pwdata  = wdata;
            state_nxt = WACCESS;
         end
         WACCESS: begin
            o_psel    = 1'b1;
            o_penable = 1'b1;
            o_pwrite  = 1'b1;
            o_paddr   = AW'(widx);
            o_pwdata  = wdata;
            state_nxt = (widx == K_LAST) ? FEED : WSETUP;
         end
         FEED: begin
            if (row == R_LAST)
               state_nxt = RUN;
         end
         RUN: begin
            o_start = 1'b1;
            if (i_done)
               state_nxt = RSETUP;
            else if (run_expired)
               state_nxt = FIN;
         end
         RSETUP: begin
            o_psel    = 1'b1;
            state_nxt = RACCESS;
         end
         RACCESS: begin
            o_psel    = 1'b1;
            o_penable = 1'b1;
            state_nxt = (rd_cnt == D_LAST) ? FIN : RSETUP;
         end
         FIN: begin
            o_end     = 1'b1;
            o_pass    = verdict;
            o_fail    = !verdict;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_in_en = {N{state == FEED}};
   assign o_sum   = sum;

   for (genvar c = 0; c < N; c++) begin : g_ch
      assign o_in_data[c*DW +: DW] = (state == FEED)
                                   ? i_iseed + DW'(row) * DW'(N) + DW'(c)
                                   : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_tpu_apb_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_tpu_apb_seq: randomized runs of tpu_apb_seq against a behavioural model.  |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module tb_tpu_apb_seq;

   localparam int N       = 2;
   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int ROWS    = 4;
   localparam int NRD     = 4;
   localparam int TIMEOUT = 16;
   localparam int BUDGET  = 400;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            go = 1'b0;
   logic [DW-1:0]   wseed = '0, wstep = '0, iseed = '0, exp_val = '0, prdata = '0;
   logic            done = 1'b0;
   logic [AW-1:0]   paddr;
   logic            psel, penable, pwrite;
   logic [DW-1:0]   pwdata;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_en;
   logic            start, busy, end_p, pass, fail, tmo;
   logic [DW-1:0]   sum;

   logic [DW-1:0]   rd_vals [NRD];
   int              n_cmp = 0;
   int              n_err = 0;

   tpu_apb_seq #(.N(N), .DW(DW), .AW(AW), .ROWS(ROWS), .NRD(NRD), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_go(go),
      .i_wseed(wseed), .i_wstep(wstep), .i_iseed(iseed), .i_expect(exp_val),
      .o_paddr(paddr), .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
      .o_pwdata(pwdata), .i_prdata(prdata),
      .o_in_data(in_data), .o_in_en(in_en), .o_start(start), .i_done(done),
      .o_busy(busy), .o_end(end_p), .o_pass(pass), .o_fail(fail),
      .o_timeout(tmo), .o_sum(sum)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_out();
      return |{paddr, psel, penable, pwrite, pwdata, in_data, in_en,
               start, busy, end_p, pass, fail, tmo, sum};
   endfunction

   // One full run: the model predicts writes, rows, reads and verdict from the inputs alone.
   task automatic run_once(input logic [DW-1:0] ws, input logic [DW-1:0] st,
                           input logic [DW-1:0] is, input bit match, input int dly,
                           input logic [DW-1:0] miss_ofs);
      logic [AW-1:0]   wa[$];
      logic [DW-1:0]   wd[$];
      logic [N*DW-1:0] rows[$];
      logic [DW-1:0]   esum;
      logic [DW-1:0]   ev;
      logic            exp_pass;
      int nrd = 0, nstart = 0, ends = 0, cyc = 0;
      bit fin = 0, prev_setup = 0;
      esum = '0;
      for (int i = 0; i < NRD; i++) esum += rd_vals[i];
      exp_val  = match ? esum : esum + miss_ofs;
      exp_pass = match;
      wseed = ws; wstep = st; iseed = is;
      go = 1'b1;
      step();
      go = 1'b0;
      check_val("launch_psel", psel, 0);
      step();
      check_val("latency_psel", psel, 1);
      while (!fin && cyc < BUDGET) begin
         go   = 1'b0;
         done = 1'b0;
         if (psel && penable) check_val("access_after_setup", prev_setup, 1);
         if (psel && pwrite && penable) begin
            wa.push_back(paddr);
            wd.push_back(pwdata);
         end
         if (in_en != '0) begin
            check_val("in_en_all", in_en, {N{1'b1}});
            rows.push_back(in_data);
         end
         if (start) begin
            nstart++;
            done = (nstart >= dly);
            if (nstart == 1) go = 1'b1;
         end
         if (psel && !pwrite && penable) begin
            check_val("rd_addr", paddr, 0);
            if (nrd < NRD) prdata = rd_vals[nrd];
            nrd++;
         end
         if (end_p) begin
            ends++;
            check_val("fin_sum", sum, esum);
            check_val("fin_pass", pass, exp_pass);
            check_val("fin_fail", fail, !exp_pass);
            check_val("fin_timeout", tmo, 0);
         end else if (ends > 0) begin
            fin = 1;
            check_val("hold_pass", pass, exp_pass);
            check_val("hold_fail", fail, !exp_pass);
            check_val("idle_busy", busy, 0);
         end
         prev_setup = psel && !penable;
         step();
         cyc++;
      end
      go = 1'b0;
      done = 1'b0;
      check_val("run_completed", fin, 1);
      check_val("n_writes", wa.size(), N*N);
      for (int k = 0; k < N*N && k < wa.size(); k++) begin
         check_val("wr_addr", wa[k], k);
         ev = ws + st * DW'(k);
         check_val("wr_data", wd[k], ev);
      end
      check_val("n_rows", rows.size(), ROWS);
      for (int r = 0; r < ROWS && r < rows.size(); r++)
         for (int c = 0; c < N; c++) begin
            ev = is + DW'(r * N + c);
            check_val("row_data", rows[r][c*DW +: DW], ev);
         end
      check_val("n_reads", nrd, NRD);
      check_val("end_cycles", ends, 1);
      step();
      check_val("post_psel", psel, 0);
      check_val("post_pass", pass, exp_pass);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      step();
      step();
      check_val("reset_outputs", any_out(), 0);
      rst = 1'b0;
      step();
      check_val("idle_busy0", busy, 0);

      rd_vals = '{32'd10, 32'd20, 32'd30, 32'd40};
      run_once(32'd1, 32'd1, 32'd1, 1'b1, 5, 32'd1);
      check_val("dir_sum100", sum, 100);

      rd_vals = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
      run_once(32'd1, 32'd1, 32'd1, 1'b0, 5, 32'd98);
      check_val("dir_sum_wrap", sum, 1);
      check_val("dir_fail", fail, 1);

      // Reset asserted mid-transfer on the third weight write.
      wseed = 32'd1; wstep = 32'd1; iseed = 32'd1;
      go = 1'b1;
      step();
      go = 1'b0;
      cyc = 0;
      while (!(psel && pwrite && paddr == 2) && cyc < 20) begin
         step();
         cyc++;
      end
      check_val("reached_third_write", psel && paddr == 2, 1);
      #2 rst = 1'b1;
      #1 check_val("async_rst_outputs", any_out(), 0);
      step();
      check_val("rst_no_verdict", {end_p, pass, fail}, 0);
      rst = 1'b0;
      step();
      check_val("after_rst_busy", busy, 0);
      rd_vals = '{32'd5, 32'd6, 32'd7, 32'd8};
      run_once(32'd1, 32'd1, 32'd1, 1'b1, 1, 32'd1);

      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < NRD; i++) rd_vals[i] = $urandom;
         run_once($urandom, $urandom, $urandom, bit'($urandom_range(0, 1)),
                  $urandom_range(1, 8), DW'($urandom_range(1, 1000)));
      end

`ifdef TPU_APB_SEQ_TIMEOUT_EN
      begin
         int nstart = 0, nrd = 0;
         bit seen = 0;
         go = 1'b1;
         step();
         go = 1'b0;
         done = 1'b0;
         cyc = 0;
         while (!seen && cyc < BUDGET) begin
            if (start) nstart++;
            if (psel && !pwrite) nrd++;
            if (end_p) begin
               seen = 1;
               check_val("tmo_flag", tmo, 1);
               check_val("tmo_fail", fail, 1);
               check_val("tmo_pass", pass, 0);
            end
            step();
            cyc++;
         end
         check_val("tmo_end_seen", seen, 1);
         check_val("tmo_run_cycles", nstart, TIMEOUT);
         check_val("tmo_no_reads", nrd, 0);
         check_val("tmo_hold", tmo, 1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tpu_apb_seq.md
TPU_APB_SEQ -- requirements
Module: tpu_apb_seq

Interface
REQ-001 Parameter N, default 2: systolic array dimension and input channel count.
REQ-002 Parameter DW, default 32: data width of APB data, input channels and checksum.
REQ-003 Parameter AW, default 32: APB address width.
REQ-004 Parameter ROWS, default 4: input vectors streamed per run.
REQ-005 Parameter NRD, default 4: result reads per run.
REQ-006 Parameter TIMEOUT, default 1024: maximum wait cycles for i_done.
REQ-007 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-008 i_rst  in  1  asynchronous, active-high reset.
REQ-009 i_go  in  1  run request, sampled in IDLE only.
REQ-010 i_wseed, i_wstep  in  DW each  weight pattern: w[k] = i_wseed + k*i_wstep.
REQ-011 i_iseed  in  DW  input pattern: in[r][c] = i_iseed + r*N + c.
REQ-012 i_expect  in  DW  expected result checksum.
REQ-013 o_paddr  out  AW; o_psel, o_penable, o_pwrite  out  1 each; o_pwdata  out  DW; i_prdata  in  DW  APB master port.
REQ-014 o_in_data  out  N*DW  channel c in bits [c*DW +: DW]; o_in_en  out  N  per-channel valid.
REQ-015 o_start  out  1; i_done  in  1  array compute handshake.
REQ-016 o_busy, o_end, o_pass, o_fail, o_timeout  out  1 each  status outputs; o_sum  out  DW  accumulated checksum.

Function
REQ-017 FSM states: IDLE, WSETUP, WACCESS, FEED, RUN, RSETUP, RACCESS, FIN.
REQ-018 IDLE with i_go=1: clear o_sum, o_pass, o_fail and o_timeout, load the run counters, and go to WSETUP on the next cycle.
REQ-019 WSETUP: o_psel=1, o_penable=0, o_pwrite=1, o_paddr=k, o_pwdata=w[k].
REQ-020 WACCESS: o_penable=1 with address and data held; k increments; go to WSETUP if k<N*N-1, else go to FEED.
REQ-021 Every APB transfer is exactly two cycles; there is no wait-state input.
REQ-022 FEED lasts exactly ROWS cycles: o_in_en is all ones and o_in_data carries row r = 0..ROWS-1, then FSM goes to RUN.
REQ-023 o_in_en is zero in every state other than FEED.
REQ-024 RUN: o_start=1, held until i_done=1 is sampled, then go to RSETUP with o_start=0 in the next cycle.
REQ-025 i_done=1 sampled on the first RUN cycle is accepted.
REQ-026 RSETUP/RACCESS: o_pwrite=0, o_paddr=0, repeated NRD times.
REQ-027 i_prdata is sampled in the RACCESS cycle and added to o_sum; the sum wraps modulo 2^DW.
REQ-028 FIN, one cycle: o_end=1, o_pass=(o_sum==i_expect), o_fail=!o_pass; then go to IDLE.
REQ-029 o_pass and o_fail hold until the next accepted i_go.
REQ-030 o_busy=1 in every state except IDLE.
REQ-031 i_go while o_busy=1 is ignored.
REQ-032 Latency: i_go sampled at edge t gives o_psel=1 after edge t+1.
REQ-033 When not in WSETUP, WACCESS, RSETUP or RACCESS: o_psel=0, o_penable=0.

Reset
REQ-034 i_rst=1 forces IDLE immediately, regardless of clock, including mid-transfer.
REQ-035 Under reset all outputs are 0, including o_in_data, o_sum and the APB outputs.
REQ-036 A reset mid-run leaves the test verdict unsignalled: o_end, o_pass and o_fail stay 0.

Configuration
REQ-037 Macro TPU_APB_SEQ_TIMEOUT_EN.
REQ-038 With TPU_APB_SEQ_TIMEOUT_EN defined: a RUN cycle counter aborts RUN after TIMEOUT cycles without i_done, sets o_timeout=1, o_fail=1, o_start=0, skips reads, and enters FIN with the verdict forced to fail.
REQ-039 Without TPU_APB_SEQ_TIMEOUT_EN: RUN waits indefinitely and o_timeout is tied to 0.

Verification
REQ-040 N=2, i_wseed=1, i_wstep=1, i_go pulse -> writes (addr,data) (0,1),(1,2),(2,3),(3,4), each psel/penable 2 cycles.
REQ-041 i_iseed=1, ROWS=4 -> FEED rows (1,2),(3,4),(5,6),(7,8) on 4 consecutive cycles, o_in_en=2'b11.
REQ-042 Model i_done after 5 cycles of o_start, reads return 10,20,30,40, i_expect=100 -> o_sum=100, o_pass=1, o_end 1-cycle pulse.
REQ-043 Same run with i_expect=99 -> o_fail=1; reads 0xFFFFFFFF,2,0,0 -> o_sum=1 (wrap).
REQ-044 i_rst pulse during the third weight write -> outputs 0 at once; a following i_go restarts at addr 0.
REQ-045 With TPU_APB_SEQ_TIMEOUT_EN and TIMEOUT=16, i_done held low -> o_timeout=1 and o_fail=1 after 16 RUN cycles, no APB reads issued.
